multi_task_ctrl: RTL and testbench
==================================

MULTI_TASK_CTRL -- requirements
Module: multi_task_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of controlled task channels (1..16).
REQ-002 Parameter RUN_POL, default all-ones NUM_CH bits, per-channel active level of ch_running (1 = active-high, 0 = active-low/shutdown style).
REQ-003 Parameter TMO_W, default 24, width of timeout counter and limit.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 task_valid  in  1  one-cycle pulse; launches a task using the inputs below.
REQ-007 task_enable  in  NUM_CH  channels started by this task.
REQ-008 task_wait_mask  in  NUM_CH  channels whose completion gates ap_done.
REQ-009 task_mode  in  1  0 = ALL masked channels done, 1 = ANY masked channel done.
REQ-010 timeout_limit  in  TMO_W  RUN-cycle budget; 0 disables timeout.
REQ-011 ch_done  in  NUM_CH  per-channel one-cycle completion pulses.
REQ-012 ch_running  out  NUM_CH  per-channel run indication at level RUN_POL[i].
REQ-013 ch_done_seen  out  NUM_CH  sticky per-channel completion status for current task.
REQ-014 ap_busy  out  1  high in RUN.
REQ-015 ap_done  out  1  sticky task completion.
REQ-016 ap_timeout  out  1  sticky task timeout.

Function
REQ-017 FSM states IDLE, RUN, DONE, TMO; task_valid in any state -> RUN next cycle.
REQ-018 On task_valid, task_wait_mask, task_mode, timeout_limit are latched; later changes have no effect until next task_valid.
REQ-019 On task_valid, internal run bits load task_enable (bits not enabled clear: a new task aborts the old one); ch_running reflects this at T+1.
REQ-020 Run bit i clears the cycle after ch_done[i] while set; ch_done[i] with run bit clear is ignored.
REQ-021 task_valid and ch_done same cycle: task_valid wins; done is discarded.
REQ-022 ch_done_seen[i] sets the cycle after an accepted ch_done[i]; all bits clear on task_valid.
REQ-023 Completion condition: mode 0 -> (seen & mask) == mask; mode 1 -> |(seen & mask).
REQ-024 In RUN, condition true -> DONE next cycle; ch_done at cycle D yields ap_done high at D+2.
REQ-025 Empty mask: mode 0 completes immediately (ap_done at T+2); mode 1 never completes (only timeout or new task exits).
REQ-026 ap_done high in DONE only; held until task_valid or rst; channels still running in DONE continue unaffected.
REQ-027 Timeout counter clears on task_valid, increments each RUN cycle, saturates at all-ones.
REQ-028 In RUN, limit != 0 and counter == limit-1 -> TMO next cycle (exactly limit RUN cycles); ap_timeout held until task_valid or rst.
REQ-029 Completion and timeout same cycle: DONE wins; ap_timeout stays 0.
REQ-030 Entering TMO clears all run bits; ch_done_seen frozen.
REQ-031 ap_done and ap_timeout never high together.

Reset
REQ-032 rst: state IDLE, run bits 0, ch_running = ~RUN_POL, ch_done_seen 0, ap_busy 0, ap_done 0, ap_timeout 0, counter 0, latched mask/mode/limit 0.
REQ-033 rst asserted mid-RUN returns to reset values the next cycle; rst overrides task_valid.

Structure
REQ-034 State encoding, mode encodings and default parameter values in shared package ctrl_pkg.
REQ-035 One sub-module chan_run_tracker, instantiated NUM_CH times: run bit, sticky seen bit, polarity output.
REQ-036 FSM, timeout counter and completion reduction in top level; outputs registered.

Verification
REQ-037 NUM_CH=4, enable=0101, mask=0101, mode 0; ch_done[0] at T+5, ch_done[2] at T+9 -> ap_done at T+11, ap_busy T+1..T+10, ch_running[2] low from T+10.
REQ-038 Mode 1, mask=0011, ch_done[1] at T+4 -> ap_done T+6; ch_running[0] stays active.
REQ-039 limit=10, no ch_done -> ap_timeout at T+11, all ch_running inactive T+11; done pulse at T+12 ignored.
REQ-040 RUN_POL=1110, task_valid enable=0001 -> ch_running[0] drops 1->0 at T+1; reset value 0001.
REQ-041 task_valid at T+6 during RUN with ch_done[0] at T+6 -> seen stays 0, counter restarts, old channels not re-enabled clear.
REQ-042 rst at T+3 mid-RUN -> all outputs at reset values at T+4; mask=0 mode 0 task -> ap_done at T+2.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-channel task controller: FSM states,
// completion modes and default parameter values.
package ctrl_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_TMO_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TMO  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_ALL = 1'b0,
    MODE_ANY = 1'b1
  } mode_t;

endpackage

// File: rtl/multi_task_ctrl_if.sv
// Task launch / channel status bundle between a task issuer (master) and
// the multi_task_ctrl block (slave).
interface multi_task_ctrl_if
  import ctrl_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int TMO_W  = DEF_TMO_W
) ();

  logic              task_valid;
  logic [NUM_CH-1:0] task_enable;
  logic [NUM_CH-1:0] task_wait_mask;
  logic              task_mode;
  logic [TMO_W-1:0]  timeout_limit;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] ch_running;
  logic [NUM_CH-1:0] ch_done_seen;
  logic              ap_busy;
  logic              ap_done;
  logic              ap_timeout;

  modport master (
    output task_valid, task_enable, task_wait_mask, task_mode, timeout_limit, ch_done,
    input  ch_running, ch_done_seen, ap_busy, ap_done, ap_timeout
  );

  modport slave (
    input  task_valid, task_enable, task_wait_mask, task_mode, timeout_limit, ch_done,
    output ch_running, ch_done_seen, ap_busy, ap_done, ap_timeout
  );

endinterface

// File: rtl/multi_task_ctrl_chan.sv
// Per-channel tracker: run bit, sticky completion bit and the run indication
// driven at the channel's configured polarity.
module chan_run_tracker #(
  parameter logic POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  input  logic done,
  input  logic kill,
  output logic running,
  output logic seen
);

  logic run_q;
  logic seen_q;
  logic accept;

  // A done pulse only counts while the channel is actually running.
  assign accept = done & run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      seen_q <= 1'b0;
    end else if (load) begin
      run_q  <= enable;
      seen_q <= 1'b0;
    end else begin
      if (kill || accept) begin
        run_q <= 1'b0;
      end
      if (accept && !kill) begin
        seen_q <= 1'b1;
      end
    end
  end

  assign running = POL ? run_q : ~run_q;
  assign seen    = seen_q;

endmodule

// File: rtl/multi_task_ctrl.sv
// Multi-channel task controller: launches channel groups, waits for ALL/ANY
// masked completions, and enforces an optional RUN-cycle timeout.
module multi_task_ctrl
  import ctrl_pkg::*;
#(
  parameter int                NUM_CH  = DEF_NUM_CH,
  parameter logic [NUM_CH-1:0] RUN_POL = '1,
  parameter int                TMO_W   = DEF_TMO_W
) (
  input logic              clk,
  input logic              rst,
  multi_task_ctrl_if.slave bus
);

  state_t            state_q;
  state_t            state_d;
  logic [NUM_CH-1:0] mask_q;
  mode_t             mode_q;
  logic [TMO_W-1:0]  limit_q;
  logic [TMO_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] run_vec;
  logic [NUM_CH-1:0] seen_vec;
  logic              complete;
  logic              tmo_hit;
  logic              kill;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    chan_run_tracker #(
      .POL(RUN_POL[i])
    ) u_trk (
      .clk     (clk),
      .rst     (rst),
      .load    (bus.task_valid),
      .enable  (bus.task_enable[i]),
      .done    (bus.ch_done[i]),
      .kill    (kill),
      .running (run_vec[i]),
      .seen    (seen_vec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q  <= '0;
      mode_q  <= MODE_ALL;
      limit_q <= '0;
    end else if (bus.task_valid) begin
      mask_q  <= bus.task_wait_mask;
      mode_q  <= mode_t'(bus.task_mode);
      limit_q <= bus.timeout_limit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.task_valid) begin
      cnt_q <= '0;
    end else if (state_q == ST_RUN && cnt_q != '1) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  // Completion is evaluated on the registered seen bits, so a done pulse at
  // cycle D moves the FSM to DONE on the edge ending D+1.
  always_comb begin
    complete = 1'b0;
    if (mode_q == MODE_ANY) begin
      complete = |(seen_vec & mask_q);
    end else begin
      complete = ((seen_vec & mask_q) == mask_q);
    end
  end

  assign tmo_hit = (limit_q != '0) && (cnt_q == limit_q - TMO_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kill    = 1'b0;
    if (bus.task_valid) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (complete) begin
            state_d = ST_DONE;
          end else if (tmo_hit) begin
            state_d = ST_TMO;
            kill    = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign bus.ap_busy      = (state_q == ST_RUN);
  assign bus.ap_done      = (state_q == ST_DONE);
  assign bus.ap_timeout   = (state_q == ST_TMO);
  assign bus.ch_running   = run_vec;
  assign bus.ch_done_seen = seen_vec;

endmodule

// File: tb/tb_multi_task_ctrl.sv
// Scoreboard bench for multi_task_ctrl: scenarios schedule cycle-stamped
// expectations which a negedge monitor pops and compares.
module tb_multi_task_ctrl;

  typedef enum int {S_BUSY, S_DONE, S_TMO, S_RUN, S_SEEN, S_RUNB, S_DONEB} sel_t;
  typedef struct {
    int          cyc;
    sel_t        sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multi_task_ctrl_if #(.NUM_CH(4), .TMO_W(24)) a_if ();
  multi_task_ctrl_if #(.NUM_CH(4), .TMO_W(24)) b_if ();

  multi_task_ctrl #(.NUM_CH(4), .RUN_POL(4'b1111), .TMO_W(24)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  multi_task_ctrl #(.NUM_CH(4), .RUN_POL(4'b1110), .TMO_W(24)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] observe(input sel_t s);
    case (s)
      S_BUSY:  return 32'(a_if.ap_busy);
      S_DONE:  return 32'(a_if.ap_done);
      S_TMO:   return 32'(a_if.ap_timeout);
      S_RUN:   return 32'(a_if.ch_running);
      S_SEEN:  return 32'(a_if.ch_done_seen);
      S_RUNB:  return 32'(b_if.ch_running);
      S_DONEB: return 32'(b_if.ap_done);
      default: return '0;
    endcase
  endfunction

  task automatic push_exp(input int c, input sel_t s, input logic [31:0] v, input string tag);
    exp_t e;
    int   i;
    e.cyc = c;
    e.sel = s;
    e.val = v;
    e.tag = tag;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, e);
  endtask

  task automatic expect_state(input int c, input string tag, input logic b, input logic d,
                              input logic t, input logic [3:0] r, input logic [3:0] s);
    push_exp(c, S_BUSY, 32'(b), $sformatf("%s@%0d.busy", tag, c));
    push_exp(c, S_DONE, 32'(d), $sformatf("%s@%0d.done", tag, c));
    push_exp(c, S_TMO,  32'(t), $sformatf("%s@%0d.tmo", tag, c));
    push_exp(c, S_RUN,  32'(r), $sformatf("%s@%0d.running", tag, c));
    push_exp(c, S_SEEN, 32'(s), $sformatf("%s@%0d.seen", tag, c));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) check_eq("exclusive", 32'(a_if.ap_done & a_if.ap_timeout), 32'd0);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) check_eq({e.tag, ".missed"}, 32'(cyc), 32'(e.cyc));
      else check_eq(e.tag, observe(e.sel), e.val);
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) next_cyc();
  endtask

  task automatic pulse(input int k, input logic [3:0] bits);
    run_to(k);
    a_if.ch_done = bits;
    next_cyc();
    a_if.ch_done = '0;
  endtask

  // Fields are scrambled after the launch cycle so anything not latched shows up.
  task automatic launch(input logic [3:0] en, input logic [3:0] mask, input logic mode,
                        input logic [23:0] lim, output int t);
    t = cyc;
    a_if.task_valid     = 1'b1;
    a_if.task_enable    = en;
    a_if.task_wait_mask = mask;
    a_if.task_mode      = mode;
    a_if.timeout_limit  = lim;
    next_cyc();
    a_if.task_valid     = 1'b0;
    a_if.task_enable    = 4'($urandom);
    a_if.task_wait_mask = 4'($urandom);
    a_if.task_mode      = 1'($urandom);
    a_if.timeout_limit  = 24'($urandom_range(1, 3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t2;
    a_if.task_valid = 1'b0; a_if.task_enable = '0; a_if.task_wait_mask = '0;
    a_if.task_mode = 1'b0; a_if.timeout_limit = '0; a_if.ch_done = '0;
    b_if.task_valid = 1'b0; b_if.task_enable = '0; b_if.task_wait_mask = '0;
    b_if.task_mode = 1'b0; b_if.timeout_limit = '0; b_if.ch_done = '0;
    repeat (3) next_cyc();
    rst = 1'b0;
    expect_state(cyc, "reset", 0, 0, 0, 4'b0000, 4'b0000);
    push_exp(cyc, S_RUNB, 32'h1, "reset.running_b");
    push_exp(cyc, S_DONEB, 32'h0, "reset.done_b");
    next_cyc();

    // ALL mode, two channels finishing at different times
    launch(4'b0101, 4'b0101, 1'b0, 24'd0, t);
    expect_state(t+1,  "all", 1, 0, 0, 4'b0101, 4'b0000);
    expect_state(t+5,  "all", 1, 0, 0, 4'b0101, 4'b0000);
    expect_state(t+6,  "all", 1, 0, 0, 4'b0100, 4'b0001);
    expect_state(t+8,  "all", 1, 0, 0, 4'b0100, 4'b0001);
    expect_state(t+10, "all", 1, 0, 0, 4'b0000, 4'b0101);
    expect_state(t+11, "all", 0, 1, 0, 4'b0000, 4'b0101);
    expect_state(t+14, "all", 0, 1, 0, 4'b0000, 4'b0101);
    pulse(t+5, 4'b0001);
    pulse(t+7, 4'b0010);
    pulse(t+9, 4'b0100);
    run_to(t+15);

    // ANY mode; unfinished channel keeps running through DONE
    launch(4'b0011, 4'b0011, 1'b1, 24'd0, t);
    expect_state(t+4, "any", 1, 0, 0, 4'b0011, 4'b0000);
    expect_state(t+5, "any", 1, 0, 0, 4'b0001, 4'b0010);
    expect_state(t+6, "any", 0, 1, 0, 4'b0001, 4'b0010);
    expect_state(t+9, "any", 0, 1, 0, 4'b0000, 4'b0011);
    pulse(t+4, 4'b0010);
    pulse(t+8, 4'b0001);
    run_to(t+10);

    // timeout after exactly 10 RUN cycles; late done ignored
    launch(4'b0110, 4'b0110, 1'b0, 24'd10, t);
    expect_state(t+4,  "tmo", 1, 0, 0, 4'b0100, 4'b0010);
    expect_state(t+10, "tmo", 1, 0, 0, 4'b0100, 4'b0010);
    expect_state(t+11, "tmo", 0, 0, 1, 4'b0000, 4'b0010);
    expect_state(t+13, "tmo", 0, 0, 1, 4'b0000, 4'b0010);
    pulse(t+3, 4'b0010);
    pulse(t+12, 4'b0110);
    run_to(t+14);

    // relaunch mid-RUN together with a done pulse
    launch(4'b0011, 4'b0011, 1'b0, 24'd8, t);
    expect_state(t+3, "abort", 1, 0, 0, 4'b0001, 4'b0010);
    pulse(t+2, 4'b0010);
    run_to(t+6);
    t2 = cyc;
    expect_state(t2+1, "relaunch", 1, 0, 0, 4'b0100, 4'b0000);
    expect_state(t2+3, "relaunch", 1, 0, 0, 4'b0100, 4'b0000);
    expect_state(t2+5, "relaunch", 1, 0, 0, 4'b0100, 4'b0000);
    expect_state(t2+6, "relaunch", 0, 0, 1, 4'b0000, 4'b0000);
    a_if.ch_done = 4'b0001;
    launch(4'b0100, 4'b0100, 1'b0, 24'd5, t2);
    a_if.ch_done = '0;
    run_to(t2+7);

    // completion and timeout on the same cycle
    launch(4'b0001, 4'b0001, 1'b0, 24'd4, t);
    expect_state(t+4, "tie", 1, 0, 0, 4'b0000, 4'b0001);
    expect_state(t+5, "tie", 0, 1, 0, 4'b0000, 4'b0001);
    expect_state(t+7, "tie", 0, 1, 0, 4'b0000, 4'b0001);
    pulse(t+3, 4'b0001);
    run_to(t+8);

    // ANY mode with empty mask never completes
    launch(4'b0001, 4'b0000, 1'b1, 24'd6, t);
    expect_state(t+3, "anyempty", 1, 0, 0, 4'b0000, 4'b0001);
    expect_state(t+6, "anyempty", 1, 0, 0, 4'b0000, 4'b0001);
    expect_state(t+7, "anyempty", 0, 0, 1, 4'b0000, 4'b0001);
    pulse(t+2, 4'b0001);
    run_to(t+8);

    // reset mid-RUN overrides a simultaneous launch
    launch(4'b0011, 4'b0011, 1'b0, 24'd0, t);
    expect_state(t+3, "midrst", 1, 0, 0, 4'b0010, 4'b0001);
    expect_state(t+4, "midrst", 0, 0, 0, 4'b0000, 4'b0000);
    expect_state(t+5, "midrst", 0, 0, 0, 4'b0000, 4'b0000);
    pulse(t+1, 4'b0001);
    run_to(t+3);
    rst = 1'b1;
    a_if.task_valid  = 1'b1;
    a_if.task_enable = 4'b1111;
    next_cyc();
    rst = 1'b0;
    a_if.task_valid = 1'b0;
    run_to(t+6);

    // ALL mode with empty mask completes immediately
    launch(4'b0000, 4'b0000, 1'b0, 24'd0, t);
    expect_state(t+1, "allempty", 1, 0, 0, 4'b0000, 4'b0000);
    expect_state(t+2, "allempty", 0, 1, 0, 4'b0000, 4'b0000);
    run_to(t+3);

    // active-low channel 0 on the second instance
    t = cyc;
    push_exp(t+1, S_RUNB, 32'h0, "pol.running_b@1");
    push_exp(t+1, S_DONEB, 32'h0, "pol.done_b@1");
    push_exp(t+4, S_RUNB, 32'h1, "pol.running_b@4");
    push_exp(t+5, S_DONEB, 32'h1, "pol.done_b@5");
    b_if.task_valid     = 1'b1;
    b_if.task_enable    = 4'b0001;
    b_if.task_wait_mask = 4'b0001;
    b_if.task_mode      = 1'b0;
    b_if.timeout_limit  = '0;
    next_cyc();
    b_if.task_valid = 1'b0;
    run_to(t+3);
    b_if.ch_done = 4'b0001;
    next_cyc();
    b_if.ch_done = '0;
    run_to(t+7);

    check_eq("pending_expectations", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
